// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core and data_mem_responder.
//   mem_addr      byte address (bits [1:0] ignored)
//   mem_data_in   write data, lane i = byte addr+i (little-endian)
//   mem_write_en  write strobe, all four lanes
//   mem_data_out  read data, same lane mapping
//   halted        core halt status, triggers the memory dump
//   oor_err       one-cycle pulse on an out-of-range access
//   dump_valid / dump_addr / dump_data / dump_done   dump stream
interface data_mem_responder_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [4];
    logic        mem_write_en;
    logic [7:0]  mem_data_out [4];
    logic        halted;
    logic        oor_err;
    logic        dump_valid;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;

    modport master (
        output mem_addr, mem_data_in, mem_write_en, halted,
        input  mem_data_out, oor_err, dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_write_en, halted,
        output mem_data_out, oor_err, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-lane data memory answering the core's word-aligned requests with a
// fixed read latency. On a halt rising edge it streams every word out on
// the dump port, then parks in DONE until reset.
//   clk    single clock, rising edge
//   rst_b  asynchronous active-low reset
//   bus    data_mem_responder_if.slave (request, response and dump signals)
module data_mem_responder #(
    parameter int SIZE_BYTES   = 65536,
    parameter int READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst_b,
    data_mem_responder_if.slave bus
);
    localparam int WORDS = SIZE_BYTES / 4;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef logic [3:0][7:0] word_t;
    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t      state, state_nx;
    word_t       mem [WORDS];
    word_t       rd_pipe [READ_LATENCY];
    word_t       wdata;
    logic        halted_q;
    logic [31:0] ptr;
    logic [AW-1:0] widx, pidx;
    logic        in_range, halt_rise, last_word;
    logic        oor_q, dump_valid_q, dump_done_q;
    logic [31:0] dump_addr_q, dump_data_q;
    logic        unused_addr_lsb;

    assign widx      = bus.mem_addr[AW+1:2];
    assign pidx      = ptr[AW+1:2];
    // Word-index compare avoids overflow when forming {addr[31:2],2'b00}.
    assign in_range  = ({2'b00, bus.mem_addr[31:2]} < 32'(WORDS));
    // halted_q resets to 0, so halted held high through reset counts as a rise.
    assign halt_rise = bus.halted & ~halted_q;
    assign last_word = (ptr == 32'(SIZE_BYTES - 4));
    assign unused_addr_lsb = ^bus.mem_addr[1:0];

    always_comb begin
        wdata = '0;
        for (int i = 0; i < 4; i++) wdata[i] = bus.mem_data_in[i];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (halt_rise) state_nx = DUMP;
            DUMP:    if (last_word) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.mem_write_en && in_range) mem[widx] <= wdata;
    end

    // ---------------- read pipe, error, dump stream ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            halted_q     <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
            oor_q        <= 1'b0;
            ptr          <= '0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
        end else begin
            halted_q <= bus.halted;
            // Read samples the pre-write contents (read-first); outside IDLE
            // the pipe keeps moving but carries zeros.
            rd_pipe[0] <= (state == IDLE && in_range) ? mem[widx] : '0;
            for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
            // One pulse covers both the read and any write on the same edge.
            oor_q        <= (state == IDLE) && !in_range;
            dump_valid_q <= (state == DUMP);
            dump_done_q  <= (state == DONE);
            if (state == DUMP) begin
                dump_addr_q <= ptr;
                dump_data_q <= mem[pidx];
                ptr         <= ptr + 32'd4;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) bus.mem_data_out[i] = rd_pipe[READ_LATENCY-1][i];
    end

    assign bus.oor_err    = oor_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_done  = dump_done_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
endmodule
